// File: rtl/truth_sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
package truth_sweep_pkg;

    localparam int unsigned NMINT = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned OP_W  = 2;

    // Gate function select
    typedef enum logic [OP_W-1:0] {
        OP_OR_NOTB = 2'd0,   // a | ~b
        OP_AND     = 2'd1,   // a & b
        OP_XOR     = 2'd2,   // a ^ b
        OP_NAND    = 2'd3    // ~(a & b)
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/truth_sweep_if.sv
// Request/result bundle between a sweep requester and the sweep controller.
interface truth_sweep_if #(
    parameter int unsigned NMINT = truth_sweep_pkg::NMINT
);
    import truth_sweep_pkg::*;

    logic             start;
    op_e              op;
    logic [NMINT-1:0] expected;
    logic             pause;
    logic             a_drv;
    logic             b_drv;
    logic             busy;
    logic             done;
    logic [NMINT-1:0] table_out;
    logic             pass;

    modport master (
        output start, op, expected, pause,
        input  a_drv, b_drv, busy, done, table_out, pass
    );

    modport slave (
        input  start, op, expected, pause,
        output a_drv, b_drv, busy, done, table_out, pass
    );
endinterface

// File: rtl/truth_sweep_gate_unit.sv
// Two-input gate under test; purely combinational function of op, a, b.
module gate_unit
    import truth_sweep_pkg::*;
(
    input  op_e  op_i,
    input  logic a_i,
    input  logic b_i,
    output logic s_o
);

    // Select one of the four gate functions
    always_comb begin
        s_o = 1'b0;
        case (op_i)
            OP_OR_NOTB: s_o = a_i | ~b_i;
            OP_AND:     s_o = a_i & b_i;
            OP_XOR:     s_o = a_i ^ b_i;
            OP_NAND:    s_o = ~(a_i & b_i);
            default:    s_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/truth_sweep_ctrl.sv
// Sweeps all minterms of a 2-input gate, captures its truth table and
// compares it with an expected table latched at start.
module truth_sweep_ctrl #(
    parameter int unsigned NMINT = truth_sweep_pkg::NMINT
) (
    input  logic       clk,
    input  logic       rst,
    truth_sweep_if.slave bus
);
    import truth_sweep_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NMINT - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    op_e              op_q, op_d;
    logic [NMINT-1:0] exp_q, exp_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [NMINT-1:0] table_q, table_d;
    logic             pass_q, pass_d;
    logic             gate_s_c;

    gate_unit u_gate (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .s_o  (gate_s_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        exp_d   = exp_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        table_d = table_q;
        pass_d  = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    exp_d   = bus.expected;
                    table_d = '0;
                    pass_d  = 1'b0;
                    idx_d   = '0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                if (!bus.pause) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (!bus.pause) begin
                    table_d[idx_q] = gate_s_c;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_CHECK;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        a_d     = idx_d[1];
                        b_d     = idx_d[0];
                        state_d = ST_APPLY;
                    end
                end
            end
            ST_CHECK: begin
                pass_d  = (table_q == exp_q);
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            op_q    <= OP_OR_NOTB;
            exp_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            table_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            exp_q   <= exp_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            table_q <= table_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.a_drv     = a_q;
    assign bus.b_drv     = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.table_out = table_q;
    assign bus.pass      = pass_q;

endmodule

// File: tb/tb_truth_sweep_ctrl.sv
// Scoreboard bench for truth_sweep_ctrl.
module tb_truth_sweep_ctrl;
    import truth_sweep_pkg::*;

    typedef struct {
        logic [3:0] tbl;
        logic       pass;
        int         done_edge;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    truth_sweep_if bus_if ();

    truth_sweep_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_cnt);
        end
    endtask

    function automatic logic [3:0] gate_ref(input logic [1:0] op);
        logic [3:0] t;
        logic       a;
        logic       b;
        t = '0;
        for (int m = 0; m < 4; m++) begin
            a = ((m / 2) % 2) == 1;
            b = (m % 2) == 1;
            case (op)
                2'd0:    t[m] = a | ~b;
                2'd1:    t[m] = a & b;
                2'd2:    t[m] = a ^ b;
                default: t[m] = ~(a & b);
            endcase
        end
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Result monitor: pop expected sweep outcome when done pulses
    always @(negedge clk) begin
        exp_t e;
        if (bus_if.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_done", 32'(bus_if.done), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("table_out", 32'(bus_if.table_out), 32'(e.tbl));
                check_eq("pass", 32'(bus_if.pass), 32'(e.pass));
                check_eq("done_cycle", 32'(edge_cnt), 32'(e.done_edge));
                check_eq("busy_in_done", 32'(bus_if.busy), 32'd0);
            end
        end
    end

    task automatic start_sweep(input logic [1:0] op, input logic [3:0] expv,
                               input logic [3:0] tbl, input logic pass,
                               input int stall, input bit track);
        bus_if.op       = op_e'(op);
        bus_if.expected = expv;
        bus_if.start    = 1'b1;
        tick();
        bus_if.start = 1'b0;
        if (track) sb_q.push_back('{tbl, pass, edge_cnt + 9 + stall});
        check_eq("busy_apply", 32'(bus_if.busy), 32'd1);
        check_eq("a_drv_first", 32'(bus_if.a_drv), 32'd0);
        check_eq("b_drv_first", 32'(bus_if.b_drv), 32'd0);
        check_eq("done_low_apply", 32'(bus_if.done), 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb_q.size() != 0) begin
            check_eq("done_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"},  32'(bus_if.busy), 32'd0);
        check_eq({tag, "_done"},  32'(bus_if.done), 32'd0);
        check_eq({tag, "_table"}, 32'(bus_if.table_out), 32'd0);
        check_eq({tag, "_pass"},  32'(bus_if.pass), 32'd0);
        check_eq({tag, "_a"},     32'(bus_if.a_drv), 32'd0);
        check_eq({tag, "_b"},     32'(bus_if.b_drv), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] rop;
        logic [3:0] rexp;
        logic [3:0] rtbl;
        int         e0;

        bus_if.start    = 1'b0;
        bus_if.op       = OP_OR_NOTB;
        bus_if.expected = '0;
        bus_if.pause    = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_all_zero("reset");

        // a|~b
        start_sweep(2'd0, 4'b1101, 4'b1101, 1'b1, 0, 1'b1);
        wait_idle(30);

        // xor, matching then mismatching expected
        start_sweep(2'd2, 4'b0110, 4'b0110, 1'b1, 0, 1'b1);
        wait_idle(30);
        start_sweep(2'd2, 4'b0111, 4'b0110, 1'b0, 0, 1'b1);
        wait_idle(30);
        repeat (3) tick();
        check_eq("table_hold_idle", 32'(bus_if.table_out), 32'h6);
        check_eq("pass_hold_idle", 32'(bus_if.pass), 32'd0);
        check_eq("busy_idle", 32'(bus_if.busy), 32'd0);

        // and, paused during cycles 3..5
        start_sweep(2'd1, 4'b1000, 4'b1000, 1'b1, 3, 1'b1);
        tick();
        tick();
        bus_if.pause = 1'b1;
        repeat (3) begin
            tick();
            check_eq("pause_a_hold", 32'(bus_if.a_drv), 32'd0);
            check_eq("pause_b_hold", 32'(bus_if.b_drv), 32'd1);
            check_eq("pause_table_hold", 32'(bus_if.table_out), 32'd0);
        end
        bus_if.pause = 1'b0;
        wait_idle(30);

        // nand, reset at cycle 5 with start and pause also high
        start_sweep(2'd3, 4'b0111, 4'b0111, 1'b1, 0, 1'b0);
        repeat (4) tick();
        rst          = 1'b1;
        bus_if.start = 1'b1;
        bus_if.pause = 1'b1;
        tick();
        rst          = 1'b0;
        bus_if.start = 1'b0;
        bus_if.pause = 1'b0;
        check_all_zero("midreset");
        repeat (12) tick();
        check_eq("post_reset_idle", 32'(bus_if.busy), 32'd0);
        start_sweep(2'd3, 4'b0111, 4'b0111, 1'b1, 0, 1'b1);
        wait_idle(30);

        // op/expected changed mid-sweep must not matter
        start_sweep(2'd0, 4'b1101, 4'b1101, 1'b1, 0, 1'b1);
        repeat (3) tick();
        bus_if.op       = OP_AND;
        bus_if.expected = 4'b0000;
        wait_idle(30);

        // start held high: back-to-back sweeps every 11 cycles
        bus_if.op       = OP_OR_NOTB;
        bus_if.expected = 4'b1101;
        bus_if.start    = 1'b1;
        tick();
        e0 = edge_cnt;
        for (int k = 0; k < 3; k++) sb_q.push_back('{4'b1101, 1'b1, e0 + 9 + 11 * k});
        check_eq("b2b_busy", 32'(bus_if.busy), 32'd1);
        wait_idle(60);
        bus_if.start = 1'b0;
        repeat (15) tick();
        check_eq("b2b_idle", 32'(bus_if.busy), 32'd0);

        // random ops and expected tables
        for (int r = 0; r < 6; r++) begin
            rop  = 2'($urandom_range(0, 3));
            rtbl = gate_ref(rop);
            rexp = ($urandom_range(0, 1) == 1) ? rtbl : 4'($urandom);
            start_sweep(rop, rexp, rtbl, (rexp == rtbl), 0, 1'b1);
            wait_idle(30);
            repeat (r % 3) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/truth_sweep_ctrl.md
TRUTH_SWEEP_CTRL -- requirements
Module: truth_sweep_ctrl

Interface
REQ-001 Parameter NMINT, default 4, number of minterms swept (2-input gate, m = {a,b}).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a sweep; honoured only in IDLE.
REQ-005 op  input  2  gate function select: 0 = a|~b, 1 = a&b, 2 = a^b, 3 = ~(a&b).
REQ-006 expected  input  4  expected truth table, bit m = output for minterm m.
REQ-007 pause  input  1  stall; freezes sweep while high.
REQ-008 a_drv, b_drv  output  1 each  registered operands applied to the gate unit.
REQ-009 busy  output  1  high from first APPLY cycle through CHECK.
REQ-010 done  output  1  one-cycle pulse when the result is valid.
REQ-011 table_out  output  4  captured truth table, bit m = gate output for minterm m.
REQ-012 pass  output  1  table_out == expected, valid from the done pulse.

Function
REQ-013 The FSM SHALL have states IDLE, APPLY, SAMPLE, CHECK, DONE.
REQ-014 IDLE & start=1 at edge: latch op and expected, clear table_out and pass, idx <= 0, go APPLY.
REQ-015 APPLY: a_drv = idx[1], b_drv = idx[0] (registered on entry); next edge -> SAMPLE.
REQ-016 SAMPLE: at edge, table_out[idx] <= gate output; if idx == NMINT-1 -> CHECK, else idx <= idx+1 -> APPLY.
REQ-017 CHECK: pass <= (table_out == latched expected); next edge -> DONE.
REQ-018 DONE: done = 1 for exactly one cycle, busy = 0; next edge -> IDLE.
REQ-019 Latency: start sampled at edge 0 -> APPLY cycles 1,3,5,7, SAMPLE 2,4,6,8, CHECK 9, done high cycle 10, IDLE cycle 11.
REQ-020 pause=1 in APPLY or SAMPLE SHALL hold state, idx, a_drv, b_drv, table_out; no capture occurs; pause ignored in IDLE, CHECK, DONE.
REQ-021 start while not IDLE (including DONE) SHALL be ignored; start in the IDLE cycle after DONE begins a new sweep.
REQ-022 op and expected changes after the start edge SHALL NOT affect the running sweep.
REQ-023 table_out and pass SHALL hold their values in IDLE until the next accepted start.
REQ-024 idx is 2 bits and SHALL NOT wrap; the NMINT-1 check ends the sweep.

Reset
REQ-025 rst=1 at an edge, in any state including mid-sweep, SHALL force IDLE, idx=0, a_drv=0, b_drv=0, busy=0, done=0, table_out=0, pass=0.
REQ-026 rst has priority over start and pause in the same cycle.

Structure
REQ-027 Package truth_sweep_pkg SHALL hold the op encodings, the FSM state type, and NMINT.
REQ-028 Sub-module gate_unit (purely combinational: op, a, b -> s) SHALL implement the four functions and be instantiated once.
REQ-029 All outputs except the gate result SHALL be registered.

Verification
REQ-030 op=0, expected=4'b1101, start pulse -> table_out=1101, pass=1, done at cycle 10.
REQ-031 op=2, expected=4'b0110 -> pass=1; repeat with expected=4'b0111 -> table_out=0110, pass=0.
REQ-032 op=1, pause high cycles 3-5 -> done delayed by 3 cycles (cycle 13), table_out=1000.
REQ-033 rst asserted at cycle 5 of an op=3 sweep -> all outputs 0 next cycle; new start gives table_out=0111.
REQ-034 start held high continuously, op=0 -> back-to-back sweeps, each done 11 cycles apart, start during busy ignored.
REQ-035 op changed from 0 to 1 at cycle 4 mid-sweep -> table_out=1101 (latched op used).
